// File: rtl/pc_serial_transmitter_pkg.sv
// Shared definitions for the serial PC link: FSM encodings and default frame geometry.
// The receiver side imports the same package so both ends agree on WIDTH/STEP.
package pc_serial_transmitter_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int STEP_DEF  = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_INCR  = 2'd2
   } state_e;

endpackage

// File: rtl/nbit_CLA_full_adder.sv
// N-bit carry-lookahead adder; each carry is formed directly from generate/propagate terms.
module nbit_CLA_full_adder
   import pc_serial_transmitter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] g;
   logic [WIDTH:0]   c;

   assign p = a_i ^ b_i;
   assign g = a_i & b_i;

   // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin, expanded without a ripple chain
   always_comb begin
      logic acc;
      logic prop;
      c    = '0;
      c[0] = cin_i;
      for (int i = 0; i < WIDTH; i++) begin
         acc  = g[i];
         prop = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            acc  = acc | (prop & g[j]);
            prop = prop & p[j];
         end
         c[i+1] = acc | (prop & cin_i);
      end
   end

   assign sum_o  = p ^ c[WIDTH-1:0];
   assign cout_o = c[WIDTH];

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shift register; shifts left so the MSB leaves first.
module piso_shift_register
   import pc_serial_transmitter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             msb_o
);

   logic [WIDTH-1:0] sr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else if (load_i) begin
         sr_q <= data_i;
      end else if (shift_i) begin
         sr_q <= {sr_q[WIDTH-2:0], 1'b0};
      end
   end

   assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/pc_serial_transmitter.sv
// Serial PC transmitter: sends the PC MSB-first with valid/ready handshake, then adds STEP.
//  state    | meaning
//  ST_IDLE  | waiting for load (PC write) or start (begin frame)
//  ST_SHIFT | presenting shift-register MSB; advances on tx_ready
//  ST_INCR  | one cycle: PC <= PC + STEP, done/wrap pulse
module pc_serial_transmitter
   import pc_serial_transmitter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int STEP  = STEP_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             tx_ready,
   output logic             tx_bit,
   output logic             tx_valid,
   output logic             tx_last,
   output logic             busy,
   output logic [WIDTH-1:0] pc,
   output logic             done,
   output logic             wrap
);

   localparam int             CW      = $clog2(WIDTH);
   localparam logic [CW-1:0]  CNT_TOP = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  CNT_ONE = CW'(1);
   localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

   state_e           state_q;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;
   logic [CW-1:0]    cnt_q;
   logic             tx_valid_q;
   logic             tx_last_q;
   logic             done_q;
   logic             wrap_q;
   logic             carry_d;
   logic             sh_load;
   logic             sh_shift;

   assign sh_load  = (state_q == ST_IDLE) && start && !load;
   assign sh_shift = (state_q == ST_SHIFT) && tx_ready && (cnt_q != '0);

   piso_shift_register #(.WIDTH(WIDTH)) u_piso (
      .clk     (clk),
      .rst_n   (reset),
      .load_i  (sh_load),
      .shift_i (sh_shift),
      .data_i  (pc_q),
      .msb_o   (tx_bit)
   );

   // pc_q is frozen outside INCR, so the carry seen while shifting is the one INCR will commit
   nbit_CLA_full_adder #(.WIDTH(WIDTH)) u_incr (
      .a_i    (pc_q),
      .b_i    (STEP_V),
      .cin_i  (1'b0),
      .sum_o  (pc_d),
      .cout_o (carry_d)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         cnt_q      <= '0;
         tx_valid_q <= 1'b0;
         tx_last_q  <= 1'b0;
         done_q     <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load) begin
                  pc_q <= load_value;
               end else if (start) begin
                  state_q    <= ST_SHIFT;
                  cnt_q      <= CNT_TOP;
                  tx_valid_q <= 1'b1;
                  tx_last_q  <= 1'b0;
               end
            end
            ST_SHIFT: begin
               if (tx_ready) begin
                  if (cnt_q == '0) begin
                     state_q    <= ST_INCR;
                     tx_valid_q <= 1'b0;
                     tx_last_q  <= 1'b0;
                     done_q     <= 1'b1;
                     wrap_q     <= carry_d;
                  end else begin
                     cnt_q     <= cnt_q - CNT_ONE;
                     tx_last_q <= (cnt_q == CNT_ONE);
                  end
               end
            end
            ST_INCR: begin
               pc_q    <= pc_d;
               done_q  <= 1'b0;
               wrap_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_valid = tx_valid_q;
   assign tx_last  = tx_last_q;
   assign busy     = (state_q != ST_IDLE);
   assign pc       = pc_q;
   assign done     = done_q;
   assign wrap     = wrap_q;

endmodule
